// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter
// -----------------------------------------------------------------------------
// Output-port allocator for one router output. Input ports whose head flit is
// routed here compete round-robin. Once a head flit wins, that input keeps the
// output until its tail flit has passed (wormhole lock). The selected flit is
// popped from its input FIFO and written into a one-entry output register.
//
// Optional build macro: NOC_ARB_PROTO_CHECK_EN enables the sticky protocol
// checker behind proto_err_o. Without the macro, proto_err_o is tied low.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   in_valid     per-input FIFO non-empty
//   in_req       per-input: head-of-FIFO flit is routed to this output
//   in_data      head-of-FIFO flits; input i at [i*FLIT_W +: FLIT_W]
//   shift_o      per-input pop strobe (one-hot or zero, combinational)
//   out_data     registered output flit
//   out_valid    out_data is valid
//   out_ready    downstream accepts out_data this cycle
//   locked_o     a packet is in progress
//   grant_o      index of the locked / last granted input
//   proto_err_o  sticky protocol error flag
// Flit format: bit FLIT_W-1 = head, bit FLIT_W-2 = tail.
// -----------------------------------------------------------------------------
module noc_out_arbiter #(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = 16,
    localparam int GW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN-1:0]        in_req,
    input  logic [NUM_IN*FLIT_W-1:0] in_data,
    output logic [NUM_IN-1:0]        shift_o,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     locked_o,
    output logic [GW-1:0]            grant_o,
    output logic                     proto_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [FLIT_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic [NUM_IN-1:0]   eligible_s;
    logic [NUM_IN-1:0]   head_s;
    logic [NUM_IN-1:0]   cand_s;
    logic                space_s;
    logic                hi_found_s, pick_found_s;
    logic [GW-1:0]       hi_idx_s, lo_idx_s, pick_idx_s;
    logic [GW-1:0]       sel_idx_s;
    logic [FLIT_W-1:0]   sel_flit_s;
    logic                sel_elig_s;
    logic                xfer_s;

    assign eligible_s = in_valid & in_req;
    assign space_s    = !out_valid_q || out_ready;

    // Extract per-input head flags and the head-flit candidate set.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            head_s[i] = in_data[i*FLIT_W + FLIT_W - 1];
        end
        cand_s = eligible_s & head_s;
    end

    // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall.
    // Scanning downward lets the last hit in each pass be the lowest index.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            hi_idx_s   = (cand_s[i] && (GW'(i) >= rr_ptr_q)) ? GW'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (cand_s[i] && (GW'(i) >= rr_ptr_q));
            lo_idx_s   = cand_s[i] ? GW'(i) : lo_idx_s;
        end
        pick_found_s = |cand_s;
        pick_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Multiplex the flit and eligibility of the currently selected input.
    always_comb begin
        sel_idx_s  = (state_q == ST_LOCKED) ? grant_q : pick_idx_s;
        sel_flit_s = '0;
        sel_elig_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_flit_s = (GW'(i) == sel_idx_s) ? in_data[i*FLIT_W +: FLIT_W] : sel_flit_s;
            sel_elig_s = (GW'(i) == sel_idx_s) ? eligible_s[i] : sel_elig_s;
        end
    end

    // Transfer decision, pop strobe and next-state logic.
    // Reset gates the transfer so nothing is popped in the reset cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE:   xfer_s = pick_found_s && space_s && !rst;
            ST_LOCKED: xfer_s = sel_elig_s && space_s && !rst;
            default:   xfer_s = 1'b0;
        endcase
        if (xfer_s) begin
            shift_o = {{(NUM_IN-1){1'b0}}, 1'b1} << sel_idx_s;
        end else begin
            shift_o = '0;
        end
        if (xfer_s) begin
            out_data_d  = sel_flit_s;
            out_valid_d = 1'b1;
            grant_d     = sel_idx_s;
            if (sel_flit_s[FLIT_W-2]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (sel_idx_s == GW'(NUM_IN - 1)) ? '0 : sel_idx_s + GW'(1);
            end else begin
                state_d  = ST_LOCKED;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Arbiter state and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked_o  = (state_q == ST_LOCKED);
    assign grant_o   = grant_q;

`ifdef NOC_ARB_PROTO_CHECK_EN
    logic [3:0]        nh_cnt_q [NUM_IN];
    logic [3:0]        nh_cnt_d [NUM_IN];
    logic              err_q, err_d;
    logic              stale_hit_s;
    logic              head_in_pkt_s;

    // Count consecutive idle cycles each input shows an eligible non-head flit;
    // the 16th such cycle (count already 15) raises the error.
    always_comb begin
        stale_hit_s   = 1'b0;
        head_in_pkt_s = (state_q == ST_LOCKED) && sel_elig_s && sel_flit_s[FLIT_W-1];
        for (int i = 0; i < NUM_IN; i++) begin
            if ((state_q == ST_IDLE) && eligible_s[i] && !head_s[i]) begin
                nh_cnt_d[i] = (nh_cnt_q[i] == 4'd15) ? nh_cnt_q[i] : nh_cnt_q[i] + 4'd1;
                stale_hit_s = stale_hit_s | (nh_cnt_q[i] == 4'd15);
            end else begin
                nh_cnt_d[i] = 4'd0;
            end
        end
        err_d = err_q | head_in_pkt_s | stale_hit_s;
    end

    // Sticky error flag and stale-flit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                nh_cnt_q[i] <= 4'd0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NUM_IN; i++) begin
                nh_cnt_q[i] <= nh_cnt_d[i];
            end
        end
    end

    assign proto_err_o = err_q;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule
